// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with per-burst ownership and per-master read-valid return.
// Optional forced handover after MAX_BURST transfers is compiled in with `define BUS_ARB_BURST_LIMIT_EN.
module bus_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0] m0_wdata,
   output logic             m0_gnt,
   output logic             m0_rvalid,
   output logic [WIDTH-1:0] m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic [WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0] m1_wdata,
   output logic             m1_gnt,
   output logic             m1_rvalid,
   output logic [WIDTH-1:0] m1_rdata,
   output logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] wdata,
   output logic             we,
   input  logic [WIDTH-1:0] rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   m0_rvalid_q, m0_rvalid_d;
   logic   m1_rvalid_q, m1_rvalid_d;
   logic   xfer0, xfer1;
   logic   burst_last;

   assign xfer0 = (state_q == OWN0) && m0_req;
   assign xfer1 = (state_q == OWN1) && m1_req;

   // An out-of-range MAX_BURST leaves this named scope in the elaborated hierarchy.
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_out_of_range
   end

`ifdef BUS_ARB_BURST_LIMIT_EN
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
   logic [7:0] burst_cnt_q, burst_cnt_d;

   assign burst_last = (burst_cnt_q == BURST_LAST);

   // Staying in an OWN state implies a transfer happened; any state change restarts the count.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (state_d != state_q || state_d == IDLE) begin
         burst_cnt_d = 8'd0;
      end else if (!burst_last) begin
         burst_cnt_d = burst_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt_q <= 8'd0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end
`else
   assign burst_last = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_d = last_q ? OWN0 : OWN1;
            end else if (m0_req) begin
               state_d = OWN0;
            end else if (m1_req) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (m0_req) begin
               if (burst_last && m1_req) begin
                  state_d = OWN1;
               end
            end else begin
               state_d = m1_req ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (m1_req) begin
               if (burst_last && m0_req) begin
                  state_d = OWN0;
               end
            end else begin
               state_d = m0_req ? OWN0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (state_d == OWN0) begin
         last_d = 1'b0;
      end else if (state_d == OWN1) begin
         last_d = 1'b1;
      end
      m0_rvalid_d = xfer0 && !m0_we;
      m1_rvalid_d = xfer1 && !m1_we;
   end

   always_comb begin
      m0_gnt = (state_q == OWN0);
      m1_gnt = (state_q == OWN1);
      addr   = '0;
      wdata  = '0;
      we     = 1'b0;
      if (xfer0) begin
         addr  = m0_addr;
         wdata = m0_wdata;
         we    = m0_we;
      end else if (xfer1) begin
         addr  = m1_addr;
         wdata = m1_wdata;
         we    = m1_we;
      end
      m0_rvalid = m0_rvalid_q;
      m1_rvalid = m1_rvalid_q;
      m0_rdata  = m0_rvalid_q ? rdata : '0;
      m1_rdata  = m1_rvalid_q ? rdata : '0;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: stimulus pushes expected bus cycles and read
// responses; a negedge monitor pops them whenever the DUT grants or raises rvalid.
module tb_bus_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         m0_req, m0_we, m1_req, m1_we;
   logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic         m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [W-1:0] m0_rdata, m1_rdata;
   logic [W-1:0] addr, wdata, rdata;
   logic         we;

   typedef struct packed {
      logic         g1;
      logic         g0;
      logic [W-1:0] a;
      logic [W-1:0] d;
      logic         we;
   } bus_exp_t;

   bus_exp_t     bus_q[$];
   logic [W-1:0] rv0_q[$];
   logic [W-1:0] rv1_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc_n  = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .addr(addr), .wdata(wdata), .we(we), .rdata(rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive inputs, push what the DUT must present this cycle (if granted)
   // and the read data a read transfer must return next cycle.
   task automatic cyc(input logic [1:0] req, input logic [1:0] wr,
                      input logic [W-1:0] a0, input logic [W-1:0] d0,
                      input logic [W-1:0] a1, input logic [W-1:0] d1,
                      input logic [1:0] eg, input logic [W-1:0] ea, input logic [W-1:0] ed,
                      input logic ewe, input logic [1:0] erd);
      bus_exp_t e;
      @(posedge clk);
      #1;
      cyc_n++;
      rdata    = 32'hD000_0000 | W'(cyc_n);
      m0_req   = req[0]; m0_we = wr[0]; m0_addr = a0; m0_wdata = d0;
      m1_req   = req[1]; m1_we = wr[1]; m1_addr = a1; m1_wdata = d1;
      if (eg != 2'b00) begin
         e.g1 = eg[1]; e.g0 = eg[0]; e.a = ea; e.d = ed; e.we = ewe;
         bus_q.push_back(e);
      end
      if (erd[0]) rv0_q.push_back(32'hD000_0000 | W'(cyc_n + 1));
      if (erd[1]) rv1_q.push_back(32'hD000_0000 | W'(cyc_n + 1));
      $display("cycle %0d req=%b we=%b gnt_exp=%b addr_exp=%h", cyc_n, req, wr, eg, ea);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (m0_gnt || m1_gnt) begin
            if (bus_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_grant: got gnt=%b%b expected none (t=%0t)", m1_gnt, m0_gnt, $time);
            end else begin
               bus_exp_t e;
               e = bus_q.pop_front();
               chk("gnt", {62'd0, m1_gnt, m0_gnt}, {62'd0, e.g1, e.g0});
               chk("addr", 64'(addr), 64'(e.a));
               chk("wdata", 64'(wdata), 64'(e.d));
               chk("we", 64'(we), 64'(e.we));
            end
         end else begin
            chk("idle_addr", 64'(addr), 64'd0);
            chk("idle_we", 64'(we), 64'd0);
         end
         if (m0_rvalid) begin
            if (rv0_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rvalid0: got rvalid=1 expected 0 (t=%0t)", $time);
            end else begin
               chk("m0_rdata", 64'(m0_rdata), 64'(rv0_q.pop_front()));
            end
         end else begin
            chk("m0_rdata_zero", 64'(m0_rdata), 64'd0);
         end
         if (m1_rvalid) begin
            if (rv1_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rvalid1: got rvalid=1 expected 0 (t=%0t)", $time);
            end else begin
               chk("m1_rdata", 64'(m1_rdata), 64'(rv1_q.pop_front()));
            end
         end else begin
            chk("m1_rdata_zero", 64'(m1_rdata), 64'd0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      rdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
      chk("rst_bus", {31'd0, we, addr}, 64'd0);
      chk("rst_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
      #2 rst_n = 1'b1;

      // Single m0 read from IDLE: grant next cycle, rvalid the cycle after.
      cyc(2'b01, 2'b00, 32'h10, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
      cyc(2'b01, 2'b00, 32'h10, 0, 0, 0, 2'b01, 32'h10, 0, 0, 2'b01);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

      // m0 write while m1 waits; direct handover once m0 drops.
      cyc(2'b01, 2'b01, 32'h2000_0000, 32'hA5, 0, 0, 2'b00, 0, 0, 0, 2'b00);
      cyc(2'b11, 2'b01, 32'h2000_0000, 32'hA5, 32'h300, 0, 2'b01, 32'h2000_0000, 32'hA5, 1, 2'b00);
      cyc(2'b10, 2'b00, 0, 0, 32'h300, 0, 2'b01, 0, 0, 0, 2'b00);
      cyc(2'b10, 2'b00, 0, 0, 32'h300, 0, 2'b10, 32'h300, 0, 0, 2'b10);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

      // m0 streams reads while m1 requests.
      cyc(2'b11, 2'b00, 32'h100, 0, 32'h400, 0, 2'b00, 0, 0, 0, 2'b00);
      for (int k = 0; k < 4; k++) begin
         cyc(2'b11, 2'b00, 32'h100 + 4 * k, 0, 32'h400, 0, 2'b01, 32'h100 + 4 * k, 0, 0, 2'b01);
      end
`ifdef BUS_ARB_BURST_LIMIT_EN
      cyc(2'b11, 2'b00, 32'h110, 0, 32'h400, 0, 2'b10, 32'h400, 0, 0, 2'b10);
      cyc(2'b01, 2'b00, 32'h110, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00);
      cyc(2'b01, 2'b00, 32'h110, 0, 0, 0, 2'b01, 32'h110, 0, 0, 2'b01);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00);
`else
      cyc(2'b11, 2'b00, 32'h110, 0, 32'h400, 0, 2'b01, 32'h110, 0, 0, 2'b01);
      cyc(2'b10, 2'b00, 0, 0, 32'h400, 0, 2'b01, 0, 0, 0, 2'b00);
      cyc(2'b10, 2'b00, 0, 0, 32'h400, 0, 2'b10, 32'h400, 0, 0, 2'b10);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00);
`endif
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

      // m1 read burst interrupted by an asynchronous reset.
      cyc(2'b10, 2'b00, 0, 0, 32'h500, 0, 2'b00, 0, 0, 0, 2'b00);
      cyc(2'b10, 2'b00, 0, 0, 32'h500, 0, 2'b10, 32'h500, 0, 0, 2'b10);
      cyc(2'b10, 2'b00, 0, 0, 32'h504, 0, 2'b10, 32'h504, 0, 0, 2'b10);
      @(posedge clk);
      #1;
      cyc_n++;
      rdata = 32'hD000_0000 | W'(cyc_n);
      m1_addr = 32'h508;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
      chk("midrst_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
      chk("midrst_we", 64'(we), 64'd0);
      chk("midrst_addr", 64'(addr), 64'd0);
      chk("midrst_rdata", 64'(m1_rdata), 64'd0);
      $display("reset pulsed during m1 burst at cycle %0d", cyc_n);
      rv0_q.delete();
      rv1_q.delete();
      m1_req = 1'b0; m1_addr = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Tie after reset goes to m0; next tie goes to m1.
      cyc(2'b11, 2'b00, 32'h600, 0, 32'h700, 0, 2'b00, 0, 0, 0, 2'b00);
      cyc(2'b11, 2'b00, 32'h600, 0, 32'h700, 0, 2'b01, 32'h600, 0, 0, 2'b01);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00);
      cyc(2'b11, 2'b00, 32'h610, 0, 32'h710, 0, 2'b00, 0, 0, 0, 2'b00);
      cyc(2'b11, 2'b00, 32'h610, 0, 32'h710, 0, 2'b10, 32'h710, 0, 0, 2'b10);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);

      @(posedge clk);
      #1;
      chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
      chk("rv0_q_drained", 64'(rv0_q.size()), 64'd0);
      chk("rv1_q_drained", 64'(rv1_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
